cla_pipe_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit combinational CLA.

---
 rtl/cla_pipe_adder.sv | 163 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor; each stage resolves WIDTH/STAGES bits with 4-bit CLA blocks.
// Latency STAGES cycles, one result per cycle; a stage advances when it is empty or its successor advances.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int S    = WIDTH / STAGES;
    localparam int NBLK = S / 4;

    // Returns {carry out, carry into bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], c[3], p ^ c[3:0]};
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic              c_q     [STAGES];

    logic              vld_in  [STAGES];
    logic [WIDTH-1:0]  a_in    [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic [WIDTH-1:0]  sum_in  [STAGES];
    logic              c_in    [STAGES];
    logic [WIDTH-1:0]  sum_nxt [STAGES];
    logic              c_nxt   [STAGES];
    logic              cm_nxt  [STAGES];

    // A stage can take new data if any stage from it to the output has a hole, or the output drains.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!vld_q[j]) adv[k] = 1'b1;
            end
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * S;
        logic [WIDTH-1:0] sum_n;
        logic             c_n;
        logic             cm_n;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1; cin is ignored in that mode.
            assign vld_in[k] = in_valid;
            assign a_in[k]   = a;
            assign b_in[k]   = sub ? ~b : b;
            assign c_in[k]   = sub | cin;
            assign sum_in[k] = '0;
        end else begin : g_body
            assign vld_in[k] = vld_q[k-1];
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        always_comb begin
            logic       c;
            logic [5:0] r;
            c     = c_in[k];
            r     = '0;
            sum_n = sum_in[k];
            cm_n  = 1'b0;
            for (int j = 0; j < NBLK; j++) begin
                r = cla4(a_in[k][LO+4*j +: 4], b_in[k][LO+4*j +: 4], c);
                sum_n[LO+4*j +: 4] = r[3:0];
                cm_n = r[4];
                c    = r[5];
            end
            c_n = c;
        end

        assign sum_nxt[k] = sum_n;
        assign c_nxt[k]   = c_n;
        assign cm_nxt[k]  = cm_n;
    end

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end
`ifdef CLA_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_in[k];
                    if (vld_in[k]) begin
                        sum_q[k] <= sum_nxt[k];
                        c_q[k]   <= c_nxt[k];
                    end
                end
            end
`ifdef CLA_PIPE_OVF_EN
            // Carry into the MSB only exists once the top slice is resolved in the last stage.
            if (adv[STAGES-1] && vld_in[STAGES-1])
                ovf_q <= cm_nxt[STAGES-1] ^ c_nxt[STAGES-1];
`endif
        end
    end

    // Unconsumed operand bits ride along without reset; they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k] && vld_in[k]) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
`ifdef CLA_PIPE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: scoreboarded 16/2 instance plus directed latency checks on 16/1 and 32/4 instances.
// Build with CLA_PIPE_OVF_EN defined to also check the overflow output.
`timescale 1ns/1ps
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
    logic        s1_in_valid, s1_in_ready, s1_cin, s1_out_valid, s1_cout;
    logic [15:0] s1_a, s1_b, s1_sum;
    logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_cout;
    logic [31:0] w_a, w_b, w_sum;
`ifdef CLA_PIPE_OVF_EN
    logic        ovf, s1_ovf, w_ovf;
`endif

    cla_pipe_adder #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .a(s1_a), .b(s1_b),
        .cin(s1_cin), .sub(1'b0), .out_valid(s1_out_valid), .out_ready(1'b1), .sum(s1_sum), .cout(s1_cout)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(s1_ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(32), .STAGES(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
        .cin(w_cin), .sub(1'b0), .out_valid(w_out_valid), .out_ready(1'b1), .sum(w_sum), .cout(w_cout)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(w_ovf)
`endif
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        exp_t        e;
        logic [16:0] r;
        if (s) begin
            r   = {1'b0, x} - {1'b0, y};
            e.s = r[15:0];
            e.c = (x >= y);
            e.o = (x[15] != y[15]) && (r[15] != x[15]);
        end else begin
            r   = {1'b0, x} + {1'b0, y} + {16'b0, c};
            e.s = r[15:0];
            e.c = r[16];
            e.o = (x[15] == y[15]) && (r[15] != x[15]);
        end
        return e;
    endfunction

    // Holds in_valid high on return so consecutive calls stream back-to-back.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            n++;
            if (n > 50) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        sb.push_back(model(x, y, c, s));
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic run_s1(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [15:0] es, input logic ec);
        @(negedge clk);
        s1_a = x; s1_b = y; s1_cin = c; s1_in_valid = 1'b1;
        #1;
        check({tag, "_rdy"}, s1_in_ready, 1);
        @(negedge clk);
        s1_in_valid = 1'b0;
        #1;
        check({tag, "_vld"}, s1_out_valid, 1);
        check({tag, "_sum"}, s1_sum, es);
        check({tag, "_cout"}, s1_cout, ec);
    endtask

    task automatic run_w32(input string tag, input logic [31:0] x, input logic [31:0] y, input logic c,
                           input logic [31:0] es, input logic ec);
        @(negedge clk);
        w_a = x; w_b = y; w_cin = c; w_in_valid = 1'b1;
        #1;
        check({tag, "_rdy"}, w_in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) w_in_valid = 1'b0;
            #1;
            if (i < 3) check({tag, "_early"}, w_out_valid, 0);
        end
        check({tag, "_vld"}, w_out_valid, 1);
        check({tag, "_sum"}, w_sum, es);
        check({tag, "_cout"}, w_cout, ec);
    endtask

    // Scoreboard consumer: every output handshake pops one expected result.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_output", out_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_sum", sum, mon_e.s);
                check("sb_cout", cout, mon_e.c);
`ifdef CLA_PIPE_OVF_EN
                check("sb_ovf", ovf, mon_e.o);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        s1_in_valid = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Two-stage latency: invalid after the accept edge, valid after the next one.
        send(16'h0001, 16'h0002, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t1_early", out_valid, 0);
        @(negedge clk);
        #1;
        check("t1_valid", out_valid, 1);
        check("t1_sum", sum, 16'h0004);
        check("t1_cout", cout, 0);
        drain();

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drain();

        // Stall: two results fill the pipe, the third waits until out_ready returns.
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h0101, 16'h0101, 1'b0, 1'b0);
        send(16'h5627, 16'h1111, 1'b0, 1'b0);
        fork
            send(16'h0001, 16'h0001, 1'b0, 1'b0);
            begin
                @(negedge clk);
                #1;
                check("t3_in_ready_low", in_ready, 0);
                for (int i = 0; i < 3; i++) begin
                    check("t3_hold_vld", out_valid, 1);
                    check("t3_hold_sum", sum, 16'h0202);
                    if (i < 2) begin
                        @(negedge clk);
                        #1;
                    end
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // Reset with two results in flight: outputs clear at once and nothing emerges afterwards.
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t6_full_vld", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", out_valid, 0);
        check("t6_rst_sum", sum, 0);
        check("t6_rst_cout", cout, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t6_in_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        #1;
        check("t6_quiet", out_valid, 0);

        run_s1("s1_t1", 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);
        run_s1("s1_t2a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_s1("s1_t2b", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_w32("w_t1", 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0);
        run_w32("w_t2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        run_w32("w_t2b", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
